// File: rtl/dynamics.sv
// Decay envelope: scales the raw oscillator sample by a gain falling from 8/8 to 0/8,
// with each gain stage lasting twice as long as the one before it.
module dynamics #(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [5:0]                 note_duration,
  input  logic signed [SAMPLE_W-1:0] sample_start,
  input  logic                       done_with_note,
  input  logic                       new_sample_ready,
  input  logic                       beat,
  output logic signed [SAMPLE_W-1:0] final_sample
);

  localparam int PROD_W = SAMPLE_W + 5;

  logic [3:0]  level_reg, level_next;
  logic [2:0]  stage_reg, stage_next;
  logic [13:0] count_reg, count_next;
  logic        beat_d_reg;
  logic signed [SAMPLE_W-1:0] final_sample_reg, final_sample_next;

  logic [5:0]  dur;
  logic [13:0] stage_len;
  logic [14:0] count_inc;
  logic        tick;
  logic signed [PROD_W-1:0] product;

  // A zero duration would make every tick end a stage, so it is clamped to one beat.
  assign dur       = (note_duration == 6'd0) ? 6'd1 : note_duration;
  assign stage_len = {8'd0, dur} << stage_reg;
  assign count_inc = {1'b0, count_reg} + 15'd1;
  assign tick      = beat & ~beat_d_reg;

  always_comb begin
    level_next = level_reg;
    stage_next = stage_reg;
    count_next = count_reg;
    if (new_sample_ready) begin
      level_next = 4'd8;
      stage_next = 3'd0;
      count_next = 14'd0;
    end else if (done_with_note) begin
      level_next = 4'd0;
    end else if (tick && (level_reg != 4'd0)) begin
      if (count_inc >= {1'b0, stage_len}) begin
        level_next = level_reg - 4'd1;
        stage_next = (stage_reg == 3'd7) ? 3'd7 : stage_reg + 3'd1;
        count_next = 14'd0;
      end else begin
        count_next = count_inc[13:0];
      end
    end
  end

  // Level is zero-extended so the product stays signed and never overflows PROD_W.
  always_comb begin
    product = $signed({{5{sample_start[SAMPLE_W-1]}}, sample_start}) *
              $signed({{(SAMPLE_W+1){1'b0}}, level_reg});
    final_sample_next = SAMPLE_W'(product >>> 3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_reg        <= 4'd8;
      stage_reg        <= 3'd0;
      count_reg        <= 14'd0;
      beat_d_reg       <= 1'b0;
      final_sample_reg <= '0;
    end else begin
      level_reg        <= level_next;
      stage_reg        <= stage_next;
      count_reg        <= count_next;
      beat_d_reg       <= beat;
      final_sample_reg <= final_sample_next;
    end
  end

  assign final_sample = final_sample_reg;

endmodule

// File: tb/tb_dynamics.sv
// Directed bench for the decay envelope: reset, full decays at two durations,
// retrigger and release priority, beat edge detection and asynchronous reset.
module tb_dynamics;

  logic               clk;
  logic               reset;
  logic [5:0]         note_duration;
  logic signed [15:0] sample_start;
  logic               done_with_note;
  logic               new_sample_ready;
  logic               beat;
  logic signed [15:0] final_sample;

  int checks = 0;
  int errors = 0;

  dynamics #(.SAMPLE_W(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .note_duration    (note_duration),
    .sample_start     (sample_start),
    .done_with_note   (done_with_note),
    .new_sample_ready (new_sample_ready),
    .beat             (beat),
    .final_sample     (final_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [15:0] exp);
    checks++;
    assert (final_sample === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, final_sample, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, final_sample, exp);
  endtask

  // One tick is one high cycle followed by two low cycles; output has settled on return.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic retrigger();
    new_sample_ready = 1'b1;
    @(negedge clk);
    new_sample_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset            = 1'b0;
    note_duration    = 6'd3;
    sample_start     = 16'sd10400;
    done_with_note   = 1'b0;
    new_sample_ready = 1'b0;
    beat             = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_held", 16'sd0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_clock", 16'sd10400);

    // Duration 3: stages end at 3, 9, 21, 45, 93, 189, 381, 765 ticks.
    ticks(2);   chk("d3_t2", 16'sd10400);
    ticks(1);   chk("d3_t3", 16'sd9100);
    ticks(6);   chk("d3_t9", 16'sd7800);
    ticks(12);  chk("d3_t21", 16'sd6500);
    ticks(24);  chk("d3_t45", 16'sd5200);
    ticks(48);  chk("d3_t93", 16'sd3900);
    ticks(96);  chk("d3_t189", 16'sd2600);
    ticks(192); chk("d3_t381", 16'sd1300);
    ticks(383); chk("d3_t764", 16'sd1300);
    ticks(1);   chk("d3_t765", 16'sd0);
    ticks(10);  chk("d3_hold0", 16'sd0);

    // Release at L=6 forces silence until the next note.
    retrigger();             chk("retrig", 16'sd10400);
    ticks(9);                chk("pre_done", 16'sd7800);
    done_with_note = 1'b1;
    @(negedge clk);
    done_with_note = 1'b0;
    @(negedge clk);          chk("done", 16'sd0);
    ticks(5);                chk("done_ticks", 16'sd0);
    sample_start = -16'sd32768;
    @(negedge clk);          chk("done_min", 16'sd0);
    retrigger();             chk("full_min", -16'sd32768);

    // Retrigger coinciding with a tick: the tick must not count.
    sample_start = 16'sd10400;
    retrigger();
    ticks(45);               chk("mid_l4", 16'sd5200);
    beat = 1'b1;
    new_sample_ready = 1'b1;
    @(negedge clk);
    beat = 1'b0;
    new_sample_ready = 1'b0;
    @(negedge clk);          chk("nsr_tick", 16'sd10400);
    ticks(2);                chk("nsr_t2", 16'sd10400);
    ticks(1);                chk("nsr_t3", 16'sd9100);

    // A long beat is a single tick.
    note_duration = 6'd1;
    retrigger();
    beat = 1'b1;
    repeat (5) @(negedge clk);
    beat = 1'b0;
    repeat (2) @(negedge clk);
    chk("long_beat", 16'sd9100);

    // Duration 0 behaves as 1: stage 1 needs two ticks.
    note_duration = 6'd0;
    retrigger();
    ticks(1);                chk("d0_t1", 16'sd9100);
    ticks(1);                chk("d0_t2", 16'sd9100);
    ticks(1);                chk("d0_t3", 16'sd7800);

    // Duration 24 on a negative sample: stages end at 24, 72, ..., 6120 ticks.
    note_duration = 6'd24;
    sample_start  = -16'sd10400;
    retrigger();             chk("d24_start", -16'sd10400);
    ticks(23);               chk("d24_t23", -16'sd10400);
    ticks(1);                chk("d24_t24", -16'sd9100);
    ticks(48);               chk("d24_t72", -16'sd7800);
    ticks(6047);             chk("d24_t6119", -16'sd1300);
    ticks(1);                chk("d24_t6120", 16'sd0);

    // Asynchronous reset mid-note.
    note_duration = 6'd3;
    sample_start  = 16'sd10400;
    retrigger();             chk("pre_areset", 16'sd10400);
    ticks(3);                chk("pre_areset2", 16'sd9100);
    #2 reset = 1'b0;
    #1 chk("async_reset", 16'sd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);          chk("post_reset", 16'sd10400);
    ticks(3);                chk("post_rst_t3", 16'sd9100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dynamics.md
Name: dynamics

Overview:
- Amplitude-envelope (decay) stage of the synth audio path.
- Takes the raw oscillator sample and scales it by a gain that falls in eighths, from 8/8 down to 0/8, over the life of a note.
- Each gain stage lasts twice as long as the previous one, giving a roughly logarithmic fade.
- Sits between the sample generator and the audio output; stage timing comes from the shared tempo `beat` pulse.

Parameters:
- SAMPLE_W, 16, width of `sample_start` and `final_sample` (two's complement).

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `note_duration`  input  6  base stage length in beats (unsigned); 0 is treated as 1.
- `sample_start`  input  SAMPLE_W  signed raw sample to be scaled.
- `done_with_note`  input  1  note released/ended; forces gain to 0.
- `new_sample_ready`  input  1  start of a new note; restarts the envelope.
- `beat`  input  1  tempo tick from the beat generator.
- `final_sample`  output  SAMPLE_W  signed scaled sample, registered.

Behaviour:
- State: gain level L (4 bits, 0..8), stage index S (3 bits), beat counter C (14 bits), `beat_d` (previous `beat`), `final_sample` register.
- Reset (`reset` low, asynchronous): L=8, S=0, C=0, beat_d=0, `final_sample`=0. On release the envelope is active at full gain; no `new_sample_ready` pulse is needed for the first note.
- Beat detection: a tick is a clock edge where `beat`=1 and `beat_d`=0, so a multi-cycle beat counts once. `beat_d` is updated every cycle.
- Stage length: D = max(`note_duration`,1). Stage S lasts D·2^S ticks, so stage 0 is D ticks, stage 1 is 2D, and so on. `note_duration` is sampled continuously; a change applies from the next comparison.
- On each tick while L>0: if C+1 ≥ D·2^S, then L←L−1, S←S+1 (saturating at 7) and C←0; otherwise C←C+1.
- At L=0 the level holds and C stops.
- `new_sample_ready`=1 on an edge: L=8, S=0, C=0. It has priority over a coincident tick and over `done_with_note`.
- `done_with_note`=1 (without `new_sample_ready`): L=0, held until the next `new_sample_ready` or reset.
- Output, every cycle: `final_sample` ← (`sample_start` × L) >>> 3, using a signed 16×5-bit product (21 bits), arithmetic shift right by 3 (floor), then truncated to 16 bits.
  - The result is exact for samples divisible by 8.
  - The L used is the value from before the current edge's update, so there is 1 cycle of latency from `sample_start` to output and 1 further cycle for a level change to appear.
- L=8 passes the sample unchanged. L=0 outputs 0 for any sample, including −32768.
- Magnitude never exceeds |`sample_start`|, so there is no overflow.
- Reset mid-note restores L=8 immediately; `final_sample` clears to 0 asynchronously.

Test Plan:
- Reset held, `sample_start`=10400 → `final_sample`=0. After release, first clock → 10400 (L=8).
- `note_duration`=3, `sample_start`=10400, `beat` one clock high every 10 clocks → after 3 ticks output 9100, after 3+6 ticks 7800, then 6500, 5200, 3900, 2600, 1300 and finally 0 after 3·255 ticks; stays 0 afterwards.
- `note_duration`=24, `sample_start`=−10400, one-cycle `new_sample_ready` → output −10400 within 2 cycles. After 24 ticks −9100, after 72 ticks −7800, …, after 24·255 ticks 0.
- `new_sample_ready` pulsed mid-decay (L=4, output 5200) coinciding with a beat tick → L=8, output returns to 10400 and the tick is ignored.
- `done_with_note` pulse at L=6 → output 0 on the following cycles despite further ticks; a later `new_sample_ready` restores full gain.
- `beat` held high 5 cycles → counts as exactly one tick. `note_duration`=0 behaves identically to 1. Asserting `reset` mid-note clears output to 0 without waiting for a clock edge.
